// File: rtl/seg_refresh_driver.sv
// Four-digit seven-segment refresh driver: captures per-digit patterns from the
// memory-mapped display register and scans them out autonomously with dead time.
module seg_refresh_driver #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] bcd7_in,
  input  logic        clear,
  output logic [3:0]  an_out,
  output logic [7:0]  seg_out,
  output logic [3:0]  digit_valid
);

  localparam int unsigned IN_W       = 12;
  localparam int unsigned AN_W       = 4;
  localparam int unsigned SEG_W      = 8;
  localparam int unsigned CNT_W      = 32;
  localparam int unsigned PTR_W      = 2;
  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [SEG_W-1:0] SEG_OFF    = {SEG_W{1'b1}};
  localparam logic [AN_W-1:0]  AN_OFF     = {AN_W{1'b1}};

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } state_t;

  logic [IN_W-1:0]  in_q;
  logic [SEG_W-1:0] digit_buf [NUM_DIGITS];
  logic             cap_en;
  logic [PTR_W-1:0] cap_idx;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [AN_W-1:0]  an_nxt;
  logic [SEG_W-1:0] seg_nxt;

  // Input register from the display register bus
  always_ff @(posedge clk or posedge reset) begin
    if (reset) in_q <= {IN_W{1'b1}};
    else       in_q <= bcd7_in;
  end

  // Only a single low anode selects a digit; idle and multi-select are ignored
  always_comb begin
    cap_en  = 1'b0;
    cap_idx = '0;
    unique case (in_q[11:8])
      4'hE: begin cap_en = 1'b1; cap_idx = PTR_W'(0); end
      4'hD: begin cap_en = 1'b1; cap_idx = PTR_W'(1); end
      4'hB: begin cap_en = 1'b1; cap_idx = PTR_W'(2); end
      4'h7: begin cap_en = 1'b1; cap_idx = PTR_W'(3); end
      default: ;
    endcase
  end

  // Digit buffers; clear takes priority over a same-cycle capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_buf[i] <= SEG_OFF;
      digit_valid <= '0;
    end else if (clear) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_buf[i] <= SEG_OFF;
      digit_valid <= '0;
    end else if (cap_en) begin
      digit_buf[cap_idx]   <= in_q[SEG_W-1:0];
      digit_valid[cap_idx] <= 1'b1;
    end
  end

  // Scan state register and registered pin drive
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= SHOW;
      ptr     <= '0;
      cnt     <= SHOW_LOAD;
      an_out  <= AN_OFF;
      seg_out <= SEG_OFF;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      cnt     <= cnt_nxt;
      an_out  <= an_nxt;
      seg_out <= seg_nxt;
    end
  end

  // Segment data is re-read every lit cycle so buffer updates show immediately
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt - CNT_W'(1);
    an_nxt    = AN_OFF;
    seg_nxt   = SEG_OFF;
    unique case (state)
      SHOW: begin
        an_nxt  = ~(AN_W'(1) << ptr);
        seg_nxt = digit_buf[ptr];
        if (cnt == '0) begin
          if (BLANK_CYCLES == 0) begin
            ptr_nxt = PTR_W'(ptr + PTR_W'(1));
            cnt_nxt = SHOW_LOAD;
          end else begin
            state_nxt = BLANK;
            cnt_nxt   = BLANK_LOAD;
          end
        end
      end
      BLANK: begin
        if (cnt == '0) begin
          state_nxt = SHOW;
          ptr_nxt   = PTR_W'(ptr + PTR_W'(1));
          cnt_nxt   = SHOW_LOAD;
        end
      end
      default: begin
        state_nxt = SHOW;
        cnt_nxt   = SHOW_LOAD;
      end
    endcase
  end

endmodule

// File: doc/seg_refresh_driver.md
# seg_refresh_driver

Autonomous four-digit seven-segment refresh driver that sits directly downstream of the data memory's memory-mapped display register. It consumes the 12-bit `bcd7` bus (anode select plus segment pattern written by software to the digit register). It captures each digit's pattern into a local buffer and then scans all four digits continuously in hardware. Software therefore writes each digit once instead of scanning in a loop. Drives the board anode and segment pins.

## Interface
- `SCAN_DIV`, default 50000: cycles each digit is lit; must be ≥1.
- `BLANK_CYCLES`, default 500: dead-time cycles between digits (anti-ghosting); 0 means no blank phase.
- `clk`  in  1  system clock; all logic rising-edge.
- `reset`  in  1  asynchronous, active-high.
- `bcd7_in`  in  12  `[11:8]` active-low anode select, `[7:0]` active-low segments (bit 7 = dp). Sourced from the digit register.
- `clear`  in  1  synchronous; blanks all buffered digits.
- `an_out`  out  4  active-low anode drive, registered.
- `seg_out`  out  8  active-low segment drive, registered.
- `digit_valid`  out  4  bit i set once digit i has been captured since reset/clear.

## Operation
- **Input stage.** `bcd7_in` is registered into `in_q` every cycle (same clock domain, no synchronizer).
- **Capture.**
  - When `in_q[11:8]` has exactly one bit low (values E, D, B, 7), `buf[i] <= in_q[7:0]` and `digit_valid[i] <= 1`. Here i is the index of the low bit.
  - `in_q[11:8] == 4'hF` (the display register's reset value): no capture.
  - Any other pattern (multiple anodes low): ignored, no state change.
  - A repeated identical value rewrites the same data; this is harmless.
- **Clear.** `clear=1`: all `buf <= 8'hFF`, `digit_valid <= 0`. `clear` wins over a same-cycle capture. Scanning is unaffected.
- **Scan FSM.** Two states, SHOW and BLANK, plus a 2-bit digit pointer `ptr` and a 32-bit down-counter `cnt`.
  - SHOW:
    - `an_out <= ~(4'b1 << ptr)`, `seg_out <= buf[ptr]`.
    - Lasts `SCAN_DIV` cycles.
    - Then goes to BLANK, or, if `BLANK_CYCLES==0`, directly to SHOW with `ptr+1`.
  - BLANK:
    - `an_out <= 4'hF`, `seg_out <= 8'hFF`.
    - Lasts `BLANK_CYCLES` cycles.
    - Then goes to SHOW with `ptr <= ptr+1`.
  - `ptr` wraps 3→0.
  - Digits with `digit_valid=0` are still given their time slot; they show 8'hFF (unlit). Frame timing is constant.
  - `seg_out` follows buffer updates while a digit is lit. It is re-read every SHOW cycle, not latched at slot entry.

## Timing
- **Reset values.** While `reset` is high:
  - `an_out=4'hF`, `seg_out=8'hFF`, `digit_valid=4'h0`
  - all `buf=8'hFF`, `in_q=12'hFFF`
  - state SHOW, `ptr=0`, `cnt` loaded for a full SHOW.
- **First edge after reset release.** `an_out=4'hE`, `seg_out=8'hFF`. Digit 0 SHOW spans the first `SCAN_DIV` edges.
- **Frame period.** 4×(`SCAN_DIV`+`BLANK_CYCLES`) cycles.
- **Capture latency.**
  - `bcd7_in` is sampled at edge N and `buf`/`digit_valid` update at edge N+1.
  - If that digit is being shown, `seg_out` reflects the new value at edge N+2.
- **Minimum input hold.** A single-cycle pulse on `bcd7_in` is sufficient for capture.
- **Reset mid-operation.** Asynchronous. Outputs go blank immediately, buffers are lost, and the scan restarts at digit 0.
- **Clear during SHOW of digit i.** `seg_out` becomes 8'hFF one cycle after the clear edge; `an_out` keeps its scan sequence.

## Test plan
Parameters: `SCAN_DIV=4`, `BLANK_CYCLES=2`.

1. **Reset, then idle with `bcd7_in=12'hFFF`.**
   - During reset: `an_out=F`, `seg_out=FF`, `digit_valid=0`.
   - After release, `an_out` sequence per edge is E,E,E,E,F,F,D,D,D,D,F,F,B…,7…, repeating every 24 cycles.
   - `seg_out` stays FF throughout.
2. **Single-cycle `bcd7_in=12'hEC0`, then back to FFF.**
   - `digit_valid=4'b0001` one edge after sampling.
   - Every digit-0 SHOW slot thereafter has `seg_out=C0`; other slots FF.
3. **Write digits `12'hEF9`, `12'hDA4`, `12'hBB0`, `12'h799` on consecutive cycles, then FFF.**
   - `digit_valid=F`.
   - Each frame shows F9, A4, B0, 99 in slots 0–3, with blanks FF between.
   - Stable for ≥3 frames.
4. **Illegal/idle anodes: `bcd7_in=12'hC00`, then `12'hF00`.**
   - No buffer or `digit_valid` change.
   - Displayed patterns identical to before.
5. **`clear=1` in the same cycle `in_q=12'hD12`.**
   - Next edge: all buffers FF, `digit_valid=0`; digit 1 not captured.
   - `an_out` sequence continues without a phase jump.
6. **Update during lit slot, then reset mid-operation.**
   - Change digit 2 pattern while digit 2 is lit: `seg_out` changes exactly 2 edges after sampling.
   - Assert `reset` asynchronously mid-SHOW of digit 2: `an_out=F` without waiting for a clock edge.
   - After release, the scan restarts at `an_out=E` with all digits FF.
